// File: rtl/sha256_ctrl.sv
// sha256_ctrl - sequencer for a single-block SHA-256 compression core.
// Accepts 16 big-endian message words over a valid/ready stream. It then
// steps the external core through INIT and 64 rounds, generating W_t on the
// fly, and presents the captured 256-bit digest over a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   msg_valid/msg_ready/msg_data       message word stream (W0 first)
//   digest_valid/digest_ready/digest_data  result {H0..H7}, H0 in MSBs
//   busy                       high outside LOAD
//   core_start/core_state/core_round/core_w  controls to the core
//   core_valid, core_out0..7   core result
module sha256_ctrl #(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msg_valid,
  output logic                    msg_ready,
  input  logic [DATA_WIDTH-1:0]   msg_data,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic [8*DATA_WIDTH-1:0] digest_data,
  output logic                    busy,
  output logic                    core_start,
  output logic [1:0]              core_state,
  output logic [5:0]              core_round,
  output logic [DATA_WIDTH-1:0]   core_w,
  input  logic                    core_valid,
  input  logic [DATA_WIDTH-1:0]   core_out0,
  input  logic [DATA_WIDTH-1:0]   core_out1,
  input  logic [DATA_WIDTH-1:0]   core_out2,
  input  logic [DATA_WIDTH-1:0]   core_out3,
  input  logic [DATA_WIDTH-1:0]   core_out4,
  input  logic [DATA_WIDTH-1:0]   core_out5,
  input  logic [DATA_WIDTH-1:0]   core_out6,
  input  logic [DATA_WIDTH-1:0]   core_out7
);

  typedef enum logic [1:0] {S_LOAD, S_INIT, S_ROUND, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_msg_ready;
  logic [3:0]              r_word_cnt;
  logic [5:0]              r_round;
  logic [DATA_WIDTH-1:0]   r_w [16];
  logic [8*DATA_WIDTH-1:0] r_digest;
  logic                    w_accept;
  logic                    w_last_round;
  logic [DATA_WIDTH-1:0]   w_new_word;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sig0(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sig1(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign w_accept     = msg_valid && r_msg_ready && (r_state == S_LOAD);
  assign w_last_round = (r_round == 6'd63);
  // Window slot i holds W[t+i] during round t, so the incoming slot is W[t+16].
  assign w_new_word   = sig1(r_w[14]) + r_w[9] + sig0(r_w[1]) + r_w[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && r_word_cnt == 4'd15) w_next_state = S_INIT;
      S_INIT:  w_next_state = S_ROUND;
      S_ROUND: if (w_last_round) w_next_state = S_DONE;
      S_DONE:  if (digest_ready) w_next_state = S_LOAD;
      default: w_next_state = S_LOAD;
    endcase
  end

  // Datapath: message window, counters, digest capture, registered msg_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_ready <= 1'b1;
      r_word_cnt  <= '0;
      r_round     <= '0;
      r_digest    <= '0;
      for (int unsigned i = 0; i < 16; i++) r_w[4'(i)] <= '0;
    end else begin
      // Ready is registered from the next state so it never asserts in the
      // cycle of the digest handoff.
      r_msg_ready <= (w_next_state == S_LOAD);
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_w[r_word_cnt] <= msg_data;
            r_word_cnt      <= (r_word_cnt == 4'd15) ? 4'd0 : r_word_cnt + 4'd1;
          end
        end
        S_INIT: r_round <= '0;
        S_ROUND: begin
          for (int unsigned i = 0; i < 15; i++) r_w[4'(i)] <= r_w[4'(i + 1)];
          r_w[15] <= w_new_word;
          r_round <= r_round + 6'd1;
          if (w_last_round && core_valid)
            r_digest <= {core_out0, core_out1, core_out2, core_out3,
                         core_out4, core_out5, core_out6, core_out7};
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    core_start   = 1'b0;
    core_state   = 2'b00;
    core_w       = '0;
    digest_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_LOAD:  busy = 1'b0;
      S_INIT:  core_start = 1'b1;
      S_ROUND: begin
        core_state = w_last_round ? 2'b10 : 2'b01;
        core_w     = r_w[0];
      end
      S_DONE: begin
        core_state   = 2'b11;
        digest_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign msg_ready   = r_msg_ready;
  assign core_round  = r_round;
  assign digest_data = r_digest;

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl - directed bench for sha256_ctrl with a behavioural SHA-256
// compression core attached to the core_* controls.
module tb_sha256_ctrl;

  localparam logic [255:0] H_INIT    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_data = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b1;
  logic [255:0] digest_data;
  logic         busy, core_start, core_valid;
  logic [1:0]   core_state;
  logic [5:0]   core_round;
  logic [31:0]  core_w;
  logic [31:0]  co [8];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] blk [16];
  logic [31:0] wref [64];

  sha256_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest_data(digest_data),
    .busy(busy), .core_start(core_start), .core_state(core_state),
    .core_round(core_round), .core_w(core_w), .core_valid(core_valid),
    .core_out0(co[0]), .core_out1(co[1]), .core_out2(co[2]), .core_out3(co[3]),
    .core_out4(co[4]), .core_out5(co[5]), .core_out6(co[6]), .core_out7(co[7]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] st, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = st;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Behavioural compression core; final round is resolved combinationally so
  // the result is present during the round-63 cycle.
  logic [255:0] cst = '0;
  logic [255:0] fin;
  always @(posedge clk) begin
    if (core_start) cst <= H_INIT;
    else if (core_state == 2'b01) cst <= rnd(cst, K[core_round], core_w);
  end
  always_comb begin
    fin = rnd(cst, K[core_round], core_w);
    for (int i = 0; i < 8; i++) co[i] = fin[255-32*i -: 32] + H_INIT[255-32*i -: 32];
    core_valid = (core_state == 2'b10);
  end

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_empty();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
  endtask

  task automatic compute_wref();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) wref[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wref[t-15], 7) ^ rotr(wref[t-15], 18) ^ (wref[t-15] >> 3);
      s1 = rotr(wref[t-2], 17) ^ rotr(wref[t-2], 19) ^ (wref[t-2] >> 10);
      wref[t] = s1 + wref[t-7] + s0 + wref[t-16];
    end
  endtask

  // Entered and left just after a falling edge; acc_edge is the index of the
  // rising edge that accepted the 16th word. msg_valid stays high on exit.
  task automatic stream_block(input bit gaps, output bit ok, output int acc_edge);
    int i;
    bit acc;
    i = 0;
    acc_edge = 0;
    for (int n = 0; n < 400 && i < 16; n++) begin
      msg_valid = gaps ? ((n % 4 != 2) && ($urandom_range(0, 3) != 0)) : 1'b1;
      msg_data  = msg_valid ? blk[i] : 32'hdeadbeef;
      acc = msg_valid && msg_ready;
      @(negedge clk);
      if (acc) begin
        i++;
        acc_edge = cyc;
      end
    end
    ok = (i == 16);
  endtask

  task automatic wait_digest(output bit ok, output int dv_edge);
    ok = 1'b0;
    dv_edge = 0;
    for (int n = 0; n < 200; n++) begin
      if (digest_valid) begin
        ok = 1'b1;
        dv_edge = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (msg_ready !== 1'b1) begin failures++; $display("FAIL rst_msg_ready got=%b exp=1", msg_ready); end
    checks++; if (digest_valid !== 1'b0) begin failures++; $display("FAIL rst_digest_valid got=%b exp=0", digest_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({core_start, core_state, core_round} !== 9'd0) begin failures++;
      $display("FAIL rst_core_ctl got=%b/%b/%0d exp=0/00/0", core_start, core_state, core_round); end
    checks++; if (core_w !== 32'd0) begin failures++; $display("FAIL rst_core_w got=%h exp=0", core_w); end
    checks++; if (digest_data !== 256'd0) begin failures++; $display("FAIL rst_digest got=%h exp=0", digest_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc_latency();
    bit ok;
    int acc, dv;
    set_abc();
    digest_ready = 1'b1;
    stream_block(1'b0, ok, acc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL abc_load_timeout got=%b exp=1", ok); end
    wait_digest(ok, dv);
    msg_valid = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL abc_digest_timeout got=%b exp=1", ok); end
    checks++; if (dv - acc !== 65) begin failures++; $display("FAIL abc_latency got=%0d exp=65", dv - acc); end
    checks++; if (digest_data !== DIG_ABC) begin failures++; $display("FAIL abc_digest got=%h exp=%h", digest_data, DIG_ABC); end
    @(negedge clk);
    checks++; if ({digest_valid, msg_ready, busy} !== 3'b010) begin failures++;
      $display("FAIL abc_handoff got=%b exp=010", {digest_valid, msg_ready, busy}); end
  endtask

  task automatic test_core_controls();
    bit ok;
    int acc;
    logic [40:0] got, exp;
    set_empty();
    compute_wref();
    stream_block(1'b0, ok, acc);
    msg_valid = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ctl_load_timeout got=%b exp=1", ok); end
    checks++; if ({core_start, core_state, busy, msg_ready} !== 5'b10010) begin failures++;
      $display("FAIL ctl_init got=%b exp=10010", {core_start, core_state, busy, msg_ready}); end
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      got = {core_start, core_state, core_round, core_w};
      exp = {1'b0, (t == 63) ? 2'b10 : 2'b01, 6'(t), wref[t]};
      checks++; if (got !== exp) begin failures++; $display("FAIL ctl_round%0d got=%h exp=%h", t, got, exp); end
    end
    @(negedge clk);
    checks++; if ({digest_valid, core_start, core_state} !== 4'b1011) begin failures++;
      $display("FAIL ctl_done got=%b exp=1011", {digest_valid, core_start, core_state}); end
    checks++; if (digest_data !== DIG_EMPTY) begin failures++; $display("FAIL ctl_digest got=%h exp=%h", digest_data, DIG_EMPTY); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc, dv;
    set_empty();
    digest_ready = 1'b0;
    stream_block(1'b1, ok, acc);
    msg_valid = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_load_timeout got=%b exp=1", ok); end
    wait_digest(ok, dv);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_digest_timeout got=%b exp=1", ok); end
    for (int n = 0; n < 20; n++) begin
      checks++; if (digest_data !== DIG_EMPTY || {digest_valid, msg_ready, busy} !== 3'b101) begin failures++;
        $display("FAIL bp_hold%0d got=%h/%b exp=%h/101", n, digest_data, {digest_valid, msg_ready, busy}, DIG_EMPTY); end
      msg_valid = (n % 2 == 0);
      @(negedge clk);
    end
    msg_valid = 1'b0;
    digest_ready = 1'b1;
    @(negedge clk);
    checks++; if ({digest_valid, msg_ready, busy} !== 3'b010) begin failures++;
      $display("FAIL bp_release got=%b exp=010", {digest_valid, msg_ready, busy}); end
  endtask

  task automatic test_reset_mid_round();
    bit ok, found;
    int acc, dv;
    set_abc();
    stream_block(1'b0, ok, acc);
    msg_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (core_state == 2'b01 && core_round == 6'd30) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL mid_reach_round30 got=%b exp=1", found); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({msg_ready, digest_valid, busy, core_start, core_state, core_round} !== 12'b100000000000) begin failures++;
      $display("FAIL mid_rst_ctl got=%b exp=100000000000", {msg_ready, digest_valid, busy, core_start, core_state, core_round}); end
    checks++; if (core_w !== 32'd0 || digest_data !== 256'd0) begin failures++;
      $display("FAIL mid_rst_data got=%h/%h exp=0/0", core_w, digest_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream_block(1'b0, ok, acc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_load_timeout got=%b exp=1", ok); end
    wait_digest(ok, dv);
    msg_valid = 1'b0;
    checks++; if (ok !== 1'b1 || digest_data !== DIG_ABC) begin failures++;
      $display("FAIL mid_digest got=%h exp=%h", digest_data, DIG_ABC); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int acc1, acc2, dv;
    digest_ready = 1'b1;
    set_abc();
    stream_block(1'b0, ok1, acc1);
    wait_digest(ok2, dv);
    checks++; if ({ok1, ok2} !== 2'b11 || digest_data !== DIG_ABC) begin failures++;
      $display("FAIL b2b_first got=%h ok=%b exp=%h", digest_data, {ok1, ok2}, DIG_ABC); end
    set_empty();
    stream_block(1'b0, ok1, acc2);
    checks++; if (acc2 - acc1 !== 82) begin failures++; $display("FAIL b2b_period got=%0d exp=82", acc2 - acc1); end
    wait_digest(ok2, dv);
    msg_valid = 1'b0;
    checks++; if ({ok1, ok2} !== 2'b11 || digest_data !== DIG_EMPTY) begin failures++;
      $display("FAIL b2b_second got=%h ok=%b exp=%h", digest_data, {ok1, ok2}, DIG_EMPTY); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_abc_latency();
    test_core_controls();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
